// File: rtl/fetch_queue_pkg.sv
// Shared definitions for the fetch queue slice: datapath width and PC step.
package fetch_queue_pkg;

  localparam int unsigned XLEN    = 32;
  localparam int unsigned PC_STEP = 4;

endpackage

// File: rtl/fetch_queue_ram.sv
// Entry storage for the fetch queue: one synchronous write port, one
// asynchronous read port. Contents are intentionally not reset.
module fetch_queue_ram #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic                 clk_i,
  input  logic                 we_i,
  input  logic [AW-1:0]        waddr_i,
  input  logic [3*WIDTH-1:0]   wdata_i,
  input  logic [AW-1:0]        raddr_i,
  output logic [3*WIDTH-1:0]   rdata_o
);

  logic [3*WIDTH-1:0] mem_q [DEPTH];

  // Write the tail entry on the rising edge when enabled.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Head entry is presented combinationally.
  always_comb begin
    rdata_o = mem_q[raddr_i];
  end

endmodule

// File: rtl/fetch_queue.sv
// Decoupling queue between fetch and decode. Captures the PC presented to
// the synchronous-read ROM, pairs it with the instruction one cycle later,
// throttles fetch before overflow and flushes on execute redirects.
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int unsigned WIDTH = XLEN,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] f_instr,
  input  logic [WIDTH-1:0] f_pc,
  output logic             pc_halt,
  output logic             pc_src,
  output logic [WIDTH-1:0] jump_val,
  input  logic             redirect_valid,
  input  logic [WIDTH-1:0] redirect_target,
  output logic             d_valid,
  input  logic             d_ready,
  output logic [WIDTH-1:0] d_instr,
  output logic [WIDTH-1:0] d_pc,
  output logic [WIDTH-1:0] d_pcPlus4
);

  localparam int unsigned AW    = $clog2(DEPTH);
  localparam int unsigned CW    = AW + 1;
  localparam logic [CW-1:0] HALT_LVL = CW'(DEPTH - 1);

  logic [AW-1:0]    head_q, head_d;
  logic [AW-1:0]    tail_q, tail_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] pc_q;
  logic             req_q;

  logic             wr_en;
  logic             pop;
  logic [WIDTH-1:0] pc_plus4;
  logic [3*WIDTH-1:0] wdata;
  logic [3*WIDTH-1:0] rdata;

  // Redirect path goes straight to the fetch PC mux with zero latency.
  always_comb begin
    pc_src   = redirect_valid;
    jump_val = redirect_target;
  end

  // Handshake and throttle; halting one entry early leaves room for the
  // ROM read that is already in flight when the halt takes effect.
  always_comb begin
    d_valid  = (count_q != '0) & ~redirect_valid;
    pc_halt  = (count_q >= HALT_LVL) & ~redirect_valid;
    pop      = d_valid & d_ready;
    wr_en    = req_q & ~redirect_valid;
    pc_plus4 = pc_q + WIDTH'(PC_STEP);
    wdata    = {f_instr, pc_q, pc_plus4};
  end

  // Pointer and occupancy next-state; a redirect discards both the pending
  // write and any pop in the same cycle.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (redirect_valid) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (wr_en) tail_d = tail_q + AW'(1);
      if (pop)   head_d = head_q + AW'(1);
      case ({wr_en, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Control state; req_q marks whether next cycle's ROM data is on-path.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      pc_q    <= '0;
      req_q   <= 1'b0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      pc_q    <= f_pc;
      req_q   <= ~pc_halt & ~redirect_valid;
    end
  end

  fetch_queue_ram #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk_i   (clk),
    .we_i    (wr_en),
    .waddr_i (tail_q),
    .wdata_i (wdata),
    .raddr_i (head_q),
    .rdata_o (rdata)
  );

  // Unpack the head entry for decode.
  always_comb begin
    d_instr   = rdata[3*WIDTH-1:2*WIDTH];
    d_pc      = rdata[2*WIDTH-1:WIDTH];
    d_pcPlus4 = rdata[WIDTH-1:0];
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: a fetch-stage model with synchronous ROM drives the
// queue; the program-order PC stream is pushed to a scoreboard as fetch
// advances and compared against every entry decode accepts.
module tb_fetch_queue;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] f_instr;
  logic [31:0] f_pc;
  logic        pc_halt;
  logic        pc_src;
  logic [31:0] jump_val;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        d_valid;
  logic        d_ready;
  logic [31:0] d_instr;
  logic [31:0] d_pc;
  logic [31:0] d_pcPlus4;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  int unsigned pops     = 0;

  logic [31:0] sb[$];
  logic [31:0] fpc;

  fetch_queue #(
    .WIDTH (32),
    .DEPTH (4)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .f_instr         (f_instr),
    .f_pc            (f_pc),
    .pc_halt         (pc_halt),
    .pc_src          (pc_src),
    .jump_val        (jump_val),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .d_valid         (d_valid),
    .d_ready         (d_ready),
    .d_instr         (d_instr),
    .d_pc            (d_pc),
    .d_pcPlus4       (d_pcPlus4)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rom(input logic [31:0] a);
    return 32'h0000_0013 ^ {a[23:0], 8'h00};
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Fetch stage model: PC register plus synchronous ROM; every newly issued
  // PC is the next instruction in program order.
  assign f_pc = fpc;
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      fpc <= 32'h0;
      sb.delete();
      sb.push_back(32'h0);
    end else begin
      f_instr <= rom(fpc);
      if (pc_src) begin
        fpc <= jump_val;
        sb.delete();
        sb.push_back(redirect_target);
      end else if (!pc_halt) begin
        fpc <= fpc + 32'd4;
        sb.push_back(fpc + 32'd4);
      end
    end
  end

  // Monitor: redirect outputs, overflow invariant, and accepted entries.
  always @(negedge clk) begin
    if (rst) begin
      check_eq("pc_src", {31'b0, pc_src}, {31'b0, redirect_valid});
      if (redirect_valid) begin
        check_eq("jump_val", jump_val, redirect_target);
        check_eq("dvalid_on_redir", {31'b0, d_valid}, 32'd0);
        check_eq("halt_on_redir", {31'b0, pc_halt}, 32'd0);
      end
      check_eq("count_bound", {31'b0, (dut.count_q <= 3'd4)}, 32'd1);
      if (d_valid && d_ready) begin
        pops++;
        if (sb.size() == 0) begin
          check_eq("sb_underflow", d_pc, 32'hDEAD_BEEF);
        end else begin
          logic [31:0] e;
          e = sb.pop_front();
          check_eq("d_pc", d_pc, e);
          check_eq("d_instr", d_instr, rom(e));
          check_eq("d_pcPlus4", d_pcPlus4, e + 32'd4);
          if (e == 32'hFFFF_FFFC) check_eq("pcplus4_wrap", d_pcPlus4, 32'h0);
        end
      end
    end
  end

  initial begin
    int unsigned p0;
    logic [31:0] t;
    rst = 1'b0;
    d_ready = 1'b0;
    redirect_valid = 1'b0;
    redirect_target = 32'h0;
    f_instr = 32'h0;

    // Reset state, with pc_src following redirect_valid during reset.
    repeat (3) tick();
    check_eq("rst_dvalid", {31'b0, d_valid}, 32'd0);
    check_eq("rst_halt", {31'b0, pc_halt}, 32'd0);
    check_eq("rst_pcsrc0", {31'b0, pc_src}, 32'd0);
    redirect_valid = 1'b1;
    redirect_target = 32'h55;
    #1;
    check_eq("rst_pcsrc1", {31'b0, pc_src}, 32'd1);
    check_eq("rst_jump", jump_val, 32'h55);
    redirect_valid = 1'b0;
    #1;

    // Fill with decode stalled: halt at count 3, saturate at 4.
    rst = 1'b1;
    for (int unsigned k = 1; k <= 8; k++) begin
      tick();
      check_eq($sformatf("fill_dvalid_%0d", k), {31'b0, d_valid}, {31'b0, (k >= 2)});
      check_eq($sformatf("fill_halt_%0d", k), {31'b0, pc_halt}, {31'b0, (k >= 4)});
    end
    check_eq("full_count", {29'b0, dut.count_q}, 32'd4);
    check_eq("full_head_pc", d_pc, 32'h0);
    d_ready = 1'b1;
    repeat (12) tick();

    // Reset release with decode ready: valid on edge 2, PCs 0,4,8.
    rst = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    check_eq("e1_dvalid", {31'b0, d_valid}, 32'd0);
    tick();
    check_eq("e2_dvalid", {31'b0, d_valid}, 32'd1);
    check_eq("e2_pc", d_pc, 32'h0);
    check_eq("e2_pc4", d_pcPlus4, 32'h4);
    tick();
    check_eq("e3_pc", d_pc, 32'h4);
    tick();
    check_eq("e4_pc", d_pc, 32'h8);
    check_eq("e4_pc4", d_pcPlus4, 32'hC);
    p0 = pops;
    repeat (20) tick();
    check_eq("throughput", pops - p0, 32'd20);

    // Fill with 0x10..0x1C, then redirect to 0x100.
    d_ready = 1'b0;
    redirect_valid = 1'b1;
    redirect_target = 32'h10;
    tick();
    redirect_valid = 1'b0;
    repeat (8) tick();
    check_eq("q10_count", {29'b0, dut.count_q}, 32'd4);
    check_eq("q10_head", d_pc, 32'h10);
    redirect_valid = 1'b1;
    redirect_target = 32'h100;
    #1;
    check_eq("r100_pcsrc", {31'b0, pc_src}, 32'd1);
    check_eq("r100_jump", jump_val, 32'h100);
    tick();
    redirect_valid = 1'b0;
    check_eq("r100_e0_dvalid", {31'b0, d_valid}, 32'd0);
    tick();
    check_eq("r100_e1_dvalid", {31'b0, d_valid}, 32'd0);
    tick();
    check_eq("r100_e2_dvalid", {31'b0, d_valid}, 32'd1);
    check_eq("r100_e2_pc", d_pc, 32'h100);
    d_ready = 1'b1;
    repeat (10) tick();

    // Back-to-back redirects: only 0x300 reaches decode.
    redirect_valid = 1'b1;
    redirect_target = 32'h200;
    tick();
    redirect_target = 32'h300;
    tick();
    redirect_valid = 1'b0;
    tick();
    tick();
    check_eq("b2b_dvalid", {31'b0, d_valid}, 32'd1);
    check_eq("b2b_pc", d_pc, 32'h300);
    repeat (10) tick();

    // Reset for one cycle while full.
    d_ready = 1'b0;
    repeat (8) tick();
    check_eq("prerst_count", {29'b0, dut.count_q}, 32'd4);
    rst = 1'b0;
    #1;
    check_eq("midrst_dvalid", {31'b0, d_valid}, 32'd0);
    check_eq("midrst_halt", {31'b0, pc_halt}, 32'd0);
    tick();
    rst = 1'b1;
    d_ready = 1'b1;
    tick();
    check_eq("postrst_e1_dvalid", {31'b0, d_valid}, 32'd0);
    tick();
    check_eq("postrst_e2_dvalid", {31'b0, d_valid}, 32'd1);
    check_eq("postrst_pc", d_pc, 32'h0);
    repeat (6) tick();

    // Address wrap across the top of the address space.
    redirect_valid = 1'b1;
    redirect_target = 32'hFFFF_FFF8;
    tick();
    redirect_valid = 1'b0;
    repeat (10) tick();

    // Random decode back-pressure and occasional redirects.
    for (int unsigned i = 0; i < 400; i++) begin
      d_ready = ($urandom_range(0, 3) != 0);
      redirect_valid = ($urandom_range(0, 19) == 0);
      t = $urandom();
      redirect_target = t & 32'hFFFF_FFFC;
      tick();
    end
    redirect_valid = 1'b0;
    d_ready = 1'b1;
    repeat (10) tick();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
